vga_overlay_arbiter: RTL and testbench
======================================

# vga_overlay_arbiter

Frame-synchronous arbiter that shares the VGA color client's overlay path (the `wRed`/`wGreen`/`wBlue`/`yes` inputs and the overlay-mode select) among `NREQ` pixel-source requesters, such as sprite or text engines. Ownership changes only at the start of vertical blanking, so the visible image never tears between two sources. The block sits between the requesters and the color client, in the same `CLK_100MHz` domain as the VGA timing generator.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `FRAME_QUOTA`, 2: frames an owner keeps the grant before it must yield to a waiting requester, 1..255.

Ports:
- `CLK_100MHz`  in  1  system clock.
- `RESET`  in  1  asynchronous, active-high reset.
- `VBlank`  in  1  vertical blanking from the timing generator.
- `HBlank`  in  1  horizontal blanking from the timing generator.
- `REQ`  in  NREQ  request levels, one per requester.
- `REQ_RED`, `REQ_GREEN`, `REQ_BLUE`  in  4*NREQ each  per-requester color; requester i uses bits [4i+3:4i].
- `REQ_HIT`  in  NREQ  per-requester "pixel is mine" flag.
- `GNT`  out  NREQ  one-hot grant, or all zero.
- `OVERLAY_EN`  out  1  overlay mode select for the color client.
- `wRed`, `wGreen`, `wBlue`  out  4 each  forwarded overlay color.
- `yes`  out  1  forwarded hit flag.

## Operation
- State machine with two states:
  - IDLE: `GNT`=0, `OVERLAY_EN`=0.
  - OWNED: exactly one `GNT` bit set, `OVERLAY_EN`=1.
- `vb_d` is a registered copy of `VBlank`. A frame boundary (FB) is the cycle where `VBlank`=1 and `vb_d`=0.
- Every decision is taken on FB only. Between FBs, `GNT`, `OVERLAY_EN`, the state, the quota counter and the round-robin pointer are frozen. This holds even if the owner drops `REQ` mid-frame.
- Round-robin pointer `last` (width clog2(NREQ)) holds the index of the most recent owner.
- The search order is `last`+1, `last`+2, … wrapping modulo NREQ, ending at `last` itself.
- Decision at FB, using `REQ` sampled in the FB cycle:
  - IDLE, no `REQ` high: stay IDLE.
  - IDLE, any `REQ` high: grant the first requesting index in search order, go to OWNED, set `qcnt`=1, set `last`=that index.
  - OWNED, owner's `REQ`=0: grant the next requester in search order, excluding the owner, and set `qcnt`=1. If there is none, go to IDLE. `last` keeps the old owner.
  - OWNED, owner's `REQ`=1, `qcnt`<`FRAME_QUOTA`: keep the grant, `qcnt`++.
  - OWNED, owner's `REQ`=1, `qcnt`=`FRAME_QUOTA`, another `REQ` high: rotate to the next in search order, `qcnt`=1.
  - OWNED, owner's `REQ`=1, `qcnt`=`FRAME_QUOTA`, no other `REQ` high: keep the grant, `qcnt` saturates at `FRAME_QUOTA`.
- `qcnt` is 8 bits and never wraps.
- Forwarding path, registered once per cycle:
  - If `VBlank`|`HBlank`, or state is IDLE: `{wRed,wGreen,wBlue}`=12'h000 and `yes`=0.
  - Otherwise: forward the owner's color slice and `REQ_HIT` bit.
- A requester that releases `REQ` mid-frame still has its color forwarded until the next FB. Requesters must keep driving valid data while `GNT` is high.

## Timing
- Reset values: all outputs 0, state IDLE, `qcnt`=0, `last`=NREQ-1 (so the first search starts at index 0), `vb_d`=0.
- Reset is asynchronous: outputs go to zero immediately on `RESET` assertion, even mid-frame or mid-line.
- After `RESET` deasserts, no grant is issued before the first FB. If `VBlank` is already 1 at deassert, that is not an FB, because `vb_d` must first see 0.
- `GNT`/`OVERLAY_EN` latency: they change on the clock edge that samples FB, so they are valid in the cycle after the FB cycle. This is always inside VBlank.
- Forwarding latency: exactly 1 cycle from `REQ_*`/`VBlank`/`HBlank` to `wRed`/`wGreen`/`wBlue`/`yes`. The timing generator's pixel coordinates must be delayed to match.
- A `REQ` edge that occurs in the FB cycle itself is honored in that FB's decision.
- A `REQ` edge one cycle after FB waits a full frame.

## Test plan
- Reset, then `REQ`=4'b0000 across 3 FBs -> `GNT`=0, `OVERLAY_EN`=0, outputs 12'h000 / `yes`=0 throughout.
- `REQ`=4'b0100 before the first FB -> `GNT`=4'b0100 and `OVERLAY_EN`=1 one cycle after FB. In the active area with `REQ_RED[11:8]`=4'hA and `REQ_HIT[2]`=1, `wRed`=4'hA and `yes`=1 one cycle later. During `HBlank`, outputs are 0.
- `REQ`=4'b1111 held, `FRAME_QUOTA`=2 -> `GNT` sequence per 2 frames: 0001, 0010, 0100, 1000, 0001.
- Owner 1 drops `REQ` mid-frame with `REQ`=4'b1000 pending -> `GNT` stays 4'b0010 and requester 1's colors are forwarded until the FB, then `GNT`=4'b1000 with `qcnt`=1.
- Sole requester 2 held for 10 frames with `FRAME_QUOTA`=2 -> `GNT`=4'b0100 continuously, `qcnt` saturates at 2, no glitch at any FB.
- `RESET` pulsed mid-line while OWNED -> all outputs 0 asynchronously. After release, the state is IDLE until the next FB, then the grant restarts from index 0.

Source files
------------

// File: rtl/vga_overlay_arbiter.sv
// Frame-synchronous arbiter sharing the VGA color client's overlay path among
// NREQ pixel sources; ownership only changes at the start of vertical blanking.
module vga_overlay_arbiter #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned FRAME_QUOTA = 2
) (
    input  logic                CLK_100MHz,
    input  logic                RESET,
    input  logic                VBlank,
    input  logic                HBlank,
    input  logic [NREQ-1:0]     REQ,
    input  logic [4*NREQ-1:0]   REQ_RED,
    input  logic [4*NREQ-1:0]   REQ_GREEN,
    input  logic [4*NREQ-1:0]   REQ_BLUE,
    input  logic [NREQ-1:0]     REQ_HIT,
    output logic [NREQ-1:0]     GNT,
    output logic                OVERLAY_EN,
    output logic [3:0]          wRed,
    output logic [3:0]          wGreen,
    output logic [3:0]          wBlue,
    output logic                yes
);

    localparam int unsigned LW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0]  QUOTA = 8'(FRAME_QUOTA);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t          state;
    logic            vb_d;
    logic            fb_armed;
    logic [7:0]      qcnt;
    logic [LW-1:0]   last;

    logic            fb_c;
    logic            owner_req_c;
    logic            any_found_c;
    logic            other_found_c;
    logic [LW-1:0]   any_pick_c;
    logic [LW-1:0]   other_pick_c;
    logic [LW-1:0]   idx_c;

    // fb_armed keeps a VBlank already high at reset release from looking like an edge
    assign fb_c        = VBlank & ~vb_d & fb_armed;
    assign owner_req_c = REQ[last];

    // Round-robin search from last+1; descending k lets the nearest requester win
    always_comb begin
        any_found_c   = 1'b0;
        other_found_c = 1'b0;
        any_pick_c    = '0;
        other_pick_c  = '0;
        idx_c         = '0;
        for (int k = int'(NREQ); k >= 1; k--) begin
            idx_c = LW'((int'(last) + k) % int'(NREQ));
            if (REQ[idx_c]) begin
                any_found_c = 1'b1;
                any_pick_c  = idx_c;
                if (k < int'(NREQ)) begin
                    other_found_c = 1'b1;
                    other_pick_c  = idx_c;
                end
            end
        end
    end

    always_ff @(posedge CLK_100MHz or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            vb_d       <= 1'b0;
            fb_armed   <= 1'b0;
            qcnt       <= 8'd0;
            last       <= LW'(NREQ - 1);
            GNT        <= '0;
            OVERLAY_EN <= 1'b0;
            wRed       <= 4'h0;
            wGreen     <= 4'h0;
            wBlue      <= 4'h0;
            yes        <= 1'b0;
        end else begin
            vb_d <= VBlank;
            if (!VBlank) begin
                fb_armed <= 1'b1;
            end

            // Overlay forwarding, blanked outside the active area or without an owner
            if (VBlank || HBlank || state == IDLE) begin
                wRed   <= 4'h0;
                wGreen <= 4'h0;
                wBlue  <= 4'h0;
                yes    <= 1'b0;
            end else begin
                wRed   <= REQ_RED[{last, 2'b00} +: 4];
                wGreen <= REQ_GREEN[{last, 2'b00} +: 4];
                wBlue  <= REQ_BLUE[{last, 2'b00} +: 4];
                yes    <= REQ_HIT[last];
            end

            if (fb_c) begin
                if (state == IDLE) begin
                    if (any_found_c) begin
                        state      <= OWNED;
                        last       <= any_pick_c;
                        GNT        <= NREQ'(1) << any_pick_c;
                        OVERLAY_EN <= 1'b1;
                        qcnt       <= 8'd1;
                    end
                end else if (owner_req_c && qcnt < QUOTA) begin
                    qcnt <= qcnt + 8'd1;
                end else if (other_found_c) begin
                    last       <= other_pick_c;
                    GNT        <= NREQ'(1) << other_pick_c;
                    OVERLAY_EN <= 1'b1;
                    qcnt       <= 8'd1;
                end else if (!owner_req_c) begin
                    state      <= IDLE;
                    GNT        <= '0;
                    OVERLAY_EN <= 1'b0;
                    qcnt       <= 8'd0;
                end
                // remaining case: sole owner at quota keeps the grant, qcnt saturated
            end
        end
    end

endmodule

// File: tb/tb_vga_overlay_arbiter.sv
// Scoreboard bench for vga_overlay_arbiter: stimulus queues expected outputs,
// a monitor pops and compares one entry after each clock or reset edge.
module tb_vga_overlay_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned QUOTA = 2;

    logic              CLK_100MHz = 1'b0;
    logic              RESET;
    logic              VBlank;
    logic              HBlank;
    logic [NREQ-1:0]   REQ;
    logic [4*NREQ-1:0] REQ_RED;
    logic [4*NREQ-1:0] REQ_GREEN;
    logic [4*NREQ-1:0] REQ_BLUE;
    logic [NREQ-1:0]   REQ_HIT;
    logic [NREQ-1:0]   GNT;
    logic              OVERLAY_EN;
    logic [3:0]        wRed;
    logic [3:0]        wGreen;
    logic [3:0]        wBlue;
    logic              yes;

    vga_overlay_arbiter #(
        .NREQ        (NREQ),
        .FRAME_QUOTA (QUOTA)
    ) dut (
        .CLK_100MHz (CLK_100MHz),
        .RESET      (RESET),
        .VBlank     (VBlank),
        .HBlank     (HBlank),
        .REQ        (REQ),
        .REQ_RED    (REQ_RED),
        .REQ_GREEN  (REQ_GREEN),
        .REQ_BLUE   (REQ_BLUE),
        .REQ_HIT    (REQ_HIT),
        .GNT        (GNT),
        .OVERLAY_EN (OVERLAY_EN),
        .wRed       (wRed),
        .wGreen     (wGreen),
        .wBlue      (wBlue),
        .yes        (yes)
    );

    always #5 CLK_100MHz = ~CLK_100MHz;

    typedef struct {
        string       name;
        logic [3:0]  gnt;
        logic        ov;
        logic [11:0] col;
        logic        hit;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Colors: red 3A21, green 8765, blue FEDC, hit 0110 -> owner color lookup
    function automatic logic [12:0] color_of(input logic [3:0] g);
        case (g)
            4'b0001: color_of = {12'h15C, 1'b0};
            4'b0010: color_of = {12'h26D, 1'b1};
            4'b0100: color_of = {12'hA7E, 1'b1};
            4'b1000: color_of = {12'h38F, 1'b0};
            default: color_of = 13'h0000;
        endcase
    endfunction

    task automatic push_exp(input string n, input logic [3:0] g,
                            input logic [11:0] c, input logic h);
        exp_t e;
        e.name = n;
        e.gnt  = g;
        e.ov   = |g;
        e.col  = c;
        e.hit  = h;
        sb.push_back(e);
    endtask

    // One cycle: drive inputs, queue the outputs expected after the next edge
    task automatic step(input string n, input logic vb, input logic hb,
                        input logic [3:0] r, input logic [3:0] g);
        logic [12:0] cy;
        VBlank = vb;
        HBlank = hb;
        REQ    = r;
        cy     = (!vb && !hb) ? color_of(g) : 13'h0000;
        push_exp(n, g, cy[12:1], cy[0]);
        @(negedge CLK_100MHz);
    endtask

    // Frame: FB cycle with r, two more blank cycles and six active cycles with rm
    task automatic frame(input string n, input logic [3:0] r,
                         input logic [3:0] rm, input logic [3:0] g);
        step(n, 1'b1, 1'b0, r, g);
        step(n, 1'b1, 1'b0, rm, g);
        step(n, 1'b1, 1'b0, rm, g);
        for (int i = 0; i < 6; i++) begin
            step(n, 1'b0, (i == 3), rm, g);
        end
    endtask

    task automatic reset_pulse();
        #2;
        push_exp("async_reset", 4'b0000, 12'h000, 1'b0);
        RESET = 1'b1;
        @(negedge CLK_100MHz);
        step("in_reset", 1'b0, 1'b0, 4'b0010, 4'b0000);
        step("in_reset", 1'b0, 1'b0, 4'b0010, 4'b0000);
        RESET = 1'b0;
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK_100MHz or posedge RESET);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (GNT !== e.gnt || OVERLAY_EN !== e.ov ||
                    {wRed, wGreen, wBlue} !== e.col || yes !== e.hit) begin
                    miscompares++;
                    $display("FAIL %s @%0t: got gnt=%b en=%b rgb=%h yes=%b, want gnt=%b en=%b rgb=%h yes=%b",
                             e.name, $time, GNT, OVERLAY_EN, {wRed, wGreen, wBlue}, yes,
                             e.gnt, e.ov, e.col, e.hit);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        RESET     = 1'b1;
        VBlank    = 1'b1;
        HBlank    = 1'b0;
        REQ       = 4'b0100;
        REQ_RED   = 16'h3A21;
        REQ_GREEN = 16'h8765;
        REQ_BLUE  = 16'hFEDC;
        REQ_HIT   = 4'b0110;
        @(negedge CLK_100MHz);
        step("reset", 1'b1, 1'b0, 4'b0100, 4'b0000);
        step("reset", 1'b1, 1'b0, 4'b0100, 4'b0000);
        RESET = 1'b0;

        // VBlank already high at release is not a frame boundary
        for (int i = 0; i < 3; i++) step("vb_at_release", 1'b1, 1'b0, 4'b0100, 4'b0000);
        for (int i = 0; i < 3; i++) step("idle_active", 1'b0, 1'b0, 4'b0100, 4'b0000);

        repeat (3) frame("no_req", 4'b0000, 4'b0000, 4'b0000);
        frame("first_grant", 4'b0100, 4'b0100, 4'b0100);
        repeat (9) frame("sole_req2", 4'b0100, 4'b0100, 4'b0100);

        frame("rotate", 4'b1111, 4'b1111, 4'b1000);
        frame("rotate", 4'b1111, 4'b1111, 4'b1000);
        frame("rotate", 4'b1111, 4'b1111, 4'b0001);
        frame("rotate", 4'b1111, 4'b1111, 4'b0001);
        frame("rotate", 4'b1111, 4'b1111, 4'b0010);

        // Owner 1 releases right after FB with 3 pending; its colors still forwarded
        frame("owner_drop", 4'b1111, 4'b1000, 4'b0010);
        frame("drop_regrant", 4'b1000, 4'b1000, 4'b1000);
        frame("regrant_qcnt1", 4'b1100, 4'b1100, 4'b1000);
        frame("regrant_rotate", 4'b1100, 4'b1100, 4'b0100);
        frame("to_idle", 4'b0000, 4'b0000, 4'b0000);

        // Request one cycle after FB waits a full frame
        frame("late_req", 4'b0000, 4'b0001, 4'b0000);
        frame("late_req_served", 4'b0001, 4'b0001, 4'b0001);
        frame("release_all", 4'b0000, 4'b0000, 4'b0000);
        // Request rising in the FB cycle is honored
        frame("fb_edge_req", 4'b0010, 4'b0010, 4'b0010);

        step("owned_active", 1'b0, 1'b0, 4'b0010, 4'b0010);
        step("owned_active", 1'b0, 1'b0, 4'b0010, 4'b0010);
        reset_pulse();
        step("post_reset", 1'b0, 1'b0, 4'b1111, 4'b0000);
        step("post_reset", 1'b0, 1'b0, 4'b1111, 4'b0000);

        frame("restart", 4'b1111, 4'b1111, 4'b0001);
        frame("restart", 4'b1111, 4'b1111, 4'b0001);
        frame("rr_seq", 4'b1111, 4'b1111, 4'b0010);
        frame("rr_seq", 4'b1111, 4'b1111, 4'b0010);
        frame("rr_seq", 4'b1111, 4'b1111, 4'b0100);
        frame("rr_seq", 4'b1111, 4'b1111, 4'b0100);
        frame("rr_seq", 4'b1111, 4'b1111, 4'b1000);
        frame("rr_seq", 4'b1111, 4'b1111, 4'b1000);
        frame("rr_seq", 4'b1111, 4'b1111, 4'b0001);

        @(negedge CLK_100MHz);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
